// File: rtl/motor_pwm_axil_slave.sv
// Motor PWM peripheral: AXI4-Lite slave exposing CTRL/PERIOD/DUTY/SCRATCH
// and driving one PWM channel plus a direction line.
module motor_pwm_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_CNT_WIDTH        = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              pwm_out,
    output logic                              pwm_dir
);

    localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

    logic                          aw_held_q, aw_held_d;
    logic [1:0]                    aw_idx_q, aw_idx_d;
    logic                          w_held_q, w_held_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [NBYTES-1:0]             w_strb_q, w_strb_d;
    logic                          bvalid_q, bvalid_d;
    logic                          awready_q, awready_d;
    logic                          wready_q, wready_d;
    logic                          arready_q, arready_d;
    logic                          rvalid_q, rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];
    logic [C_S_AXI_DATA_WIDTH-1:0] regs_d [4];

    logic [C_CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic [C_CNT_WIDTH-1:0]        per_q, per_d;
    logic [C_CNT_WIDTH-1:0]        duty_q, duty_d;
    logic                          pwm_q, pwm_d;
    logic                          dir_q, dir_d;

    logic                          enable, idle, wrap;
    logic                          unused_inputs;

    assign enable = regs_q[0][0];
    assign idle   = !enable || (per_q == '0);
    assign wrap   = !idle && (cnt_q == per_q - C_CNT_WIDTH'(1));

    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        regs_d    = regs_q;
        cnt_d     = cnt_q;
        per_d     = per_q;
        duty_d    = duty_q;

        if (S_AXI_AWVALID && awready_q) begin
            aw_held_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[3:2];
        end
        if (S_AXI_WVALID && wready_q) begin
            w_held_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end
        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        // Commit uses the held copies; the readys are already low here so no
        // new capture can collide with the clear below.
        if (aw_held_q && w_held_q) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (w_strb_q[b]) begin
                    regs_d[aw_idx_q][b*8 +: 8] = w_data_q[b*8 +: 8];
                end
            end
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
        end
        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;

        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (S_AXI_ARVALID && arready_q) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
        end
        arready_d = !rvalid_d;

        // Shadows track the registers while idle and otherwise only at a wrap.
        if (idle || wrap) begin
            per_d  = regs_q[1][C_CNT_WIDTH-1:0];
            duty_d = regs_q[2][C_CNT_WIDTH-1:0];
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + C_CNT_WIDTH'(1);
        end
        pwm_d = !idle && (cnt_q < duty_q);
        dir_d = regs_q[0][1];
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q     <= '0;
            per_q     <= '0;
            duty_q    <= '0;
            pwm_q     <= 1'b0;
            dir_q     <= 1'b0;
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
            dir_q     <= dir_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign pwm_out       = pwm_q;
    assign pwm_dir       = dir_q;

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_motor_pwm_axil_slave.sv
// Bench for motor_pwm_axil_slave: directed scenarios plus random bus traffic,
// checked against a register/PWM reference model kept in the bench.
module tb_motor_pwm_axil_slave;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [3:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [3:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic        pwm_out;
    logic        pwm_dir;

    always #5 ACLK = ~ACLK;

    motor_pwm_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .C_CNT_WIDTH(16)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .pwm_out(pwm_out), .pwm_dir(pwm_dir)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register file plus the PWM as "position within the
    // current period", with period/duty latched at period starts.
    logic [31:0] m_regs [4] = '{default: '0};
    int          m_per = 0, m_duty = 0, m_pos = 0;
    logic        exp_pwm = 1'b0, exp_dir = 1'b0;
    int          cyc = 0;
    logic        pend_v = 1'b0;
    int          pend_cyc = 0;
    logic [1:0]  pend_idx = '0;
    logic [31:0] pend_data = '0;
    logic [3:0]  pend_strb = '0;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) m_regs[i] = '0;
            m_per = 0; m_duty = 0; m_pos = 0;
            exp_pwm = 1'b0; exp_dir = 1'b0; pend_v = 1'b0;
        end else begin
            if (!m_regs[0][0] || m_per == 0) begin
                exp_pwm = 1'b0;
                m_pos   = 0;
                m_per   = int'(m_regs[1][15:0]);
                m_duty  = int'(m_regs[2][15:0]);
            end else begin
                exp_pwm = (m_pos < m_duty);
                m_pos++;
                if (m_pos == m_per) begin
                    m_pos  = 0;
                    m_per  = int'(m_regs[1][15:0]);
                    m_duty = int'(m_regs[2][15:0]);
                end
            end
            exp_dir = m_regs[0][1];
            if (pend_v && pend_cyc == cyc) begin
                for (int b = 0; b < 4; b++)
                    if (pend_strb[b]) m_regs[pend_idx][b*8 +: 8] = pend_data[b*8 +: 8];
                pend_v = 1'b0;
            end
            cyc++;
        end
    end

    always @(negedge ACLK) begin
        chk("pwm_out", {31'b0, pwm_out}, {31'b0, exp_pwm});
        chk("pwm_dir", {31'b0, pwm_dir}, {31'b0, exp_dir});
    end

    // gap > 0: W leads AW by gap cycles; gap < 0: AW leads W.
    task automatic axi_write(input logic [1:0] idx, input logic [31:0] data,
                             input logic [3:0] strb, input int gap, input int bdelay);
        int aw_at, w_at, last;
        aw_at = (gap > 0) ? gap : 0;
        w_at  = (gap < 0) ? -gap : 0;
        last  = (aw_at > w_at) ? aw_at : w_at;
        pend_v = 1'b1; pend_cyc = cyc + last + 1;
        pend_idx = idx; pend_data = data; pend_strb = strb;
        S_AXI_BREADY = (bdelay == 0);
        for (int k = 0; k <= last; k++) begin
            if (k == aw_at) begin
                chk("awready_idle", {31'b0, S_AXI_AWREADY}, 32'd1);
                S_AXI_AWADDR  = {idx, 2'($urandom_range(0, 3))};
                S_AXI_AWPROT  = 3'($urandom);
                S_AXI_AWVALID = 1'b1;
            end
            if (k == w_at) begin
                chk("wready_idle", {31'b0, S_AXI_WREADY}, 32'd1);
                S_AXI_WDATA  = data;
                S_AXI_WSTRB  = strb;
                S_AXI_WVALID = 1'b1;
            end
            @(negedge ACLK);
            if (k == aw_at) S_AXI_AWVALID = 1'b0;
            if (k == w_at)  S_AXI_WVALID  = 1'b0;
            if (k >= aw_at) chk("awready_held", {31'b0, S_AXI_AWREADY}, 32'd0);
            if (k >= w_at)  chk("wready_held", {31'b0, S_AXI_WREADY}, 32'd0);
            chk("bvalid_early", {31'b0, S_AXI_BVALID}, 32'd0);
        end
        @(negedge ACLK);
        chk("bvalid_set", {31'b0, S_AXI_BVALID}, 32'd1);
        chk("bresp", {30'b0, S_AXI_BRESP}, 32'd0);
        repeat (bdelay) begin
            chk("awready_during_b", {31'b0, S_AXI_AWREADY}, 32'd0);
            chk("wready_during_b", {31'b0, S_AXI_WREADY}, 32'd0);
            @(negedge ACLK);
            chk("bvalid_hold", {31'b0, S_AXI_BVALID}, 32'd1);
        end
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        chk("bvalid_clear", {31'b0, S_AXI_BVALID}, 32'd0);
        chk("awready_back", {31'b0, S_AXI_AWREADY}, 32'd1);
        chk("wready_back", {31'b0, S_AXI_WREADY}, 32'd1);
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [1:0] idx, input int rdelay, output logic [31:0] got);
        logic [31:0] exp;
        chk("arready_idle", {31'b0, S_AXI_ARREADY}, 32'd1);
        exp = m_regs[idx];
        S_AXI_ARADDR  = {idx, 2'($urandom_range(0, 3))};
        S_AXI_ARPROT  = 3'($urandom);
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = (rdelay == 0);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        chk("rvalid_set", {31'b0, S_AXI_RVALID}, 32'd1);
        chk("rresp", {30'b0, S_AXI_RRESP}, 32'd0);
        chk("rdata", S_AXI_RDATA, exp);
        chk("arready_busy", {31'b0, S_AXI_ARREADY}, 32'd0);
        got = S_AXI_RDATA;
        repeat (rdelay) begin
            @(negedge ACLK);
            chk("rvalid_hold", {31'b0, S_AXI_RVALID}, 32'd1);
            chk("rdata_hold", S_AXI_RDATA, exp);
        end
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        chk("rvalid_clear", {31'b0, S_AXI_RVALID}, 32'd0);
        chk("arready_back", {31'b0, S_AXI_ARREADY}, 32'd1);
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge ACLK);
            if (pwm_out) hi++;
        end
    endtask

    task automatic check_all_outputs_zero(input string tag);
        chk({tag, "_awready"}, {31'b0, S_AXI_AWREADY}, 32'd0);
        chk({tag, "_wready"}, {31'b0, S_AXI_WREADY}, 32'd0);
        chk({tag, "_arready"}, {31'b0, S_AXI_ARREADY}, 32'd0);
        chk({tag, "_bvalid"}, {31'b0, S_AXI_BVALID}, 32'd0);
        chk({tag, "_rvalid"}, {31'b0, S_AXI_RVALID}, 32'd0);
        chk({tag, "_rdata"}, S_AXI_RDATA, 32'd0);
        chk({tag, "_pwm_out"}, {31'b0, pwm_out}, 32'd0);
        chk({tag, "_pwm_dir"}, {31'b0, pwm_dir}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int          hi;
        repeat (3) @(negedge ACLK);
        check_all_outputs_zero("reset");
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("post_reset_awready", {31'b0, S_AXI_AWREADY}, 32'd1);
        chk("post_reset_wready", {31'b0, S_AXI_WREADY}, 32'd1);
        chk("post_reset_arready", {31'b0, S_AXI_ARREADY}, 32'd1);

        // Smoke sweep
        for (int i = 0; i < 4; i++) axi_write(2'(i), 32'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) begin
            axi_read(2'(i), 0, got);
            chk("smoke_readback", got, 32'(i + 1));
        end

        // Byte-lane write
        axi_write(2'd3, 32'hFFFF_FFFF, 4'hF, 0, 0);
        axi_write(2'd3, 32'h0000_00AB, 4'h1, 0, 0);
        axi_read(2'd3, 1, got);
        chk("strb_readback", got, 32'hFFFF_FFAB);

        // Read handshake on the same edge as a write commit sees the old value
        fork
            axi_write(2'd3, 32'h5555_AAAA, 4'hF, 0, 0);
            begin
                @(negedge ACLK);
                axi_read(2'd3, 0, got);
            end
        join
        chk("same_edge_old", got, 32'hFFFF_FFAB);
        axi_read(2'd3, 0, got);
        chk("same_edge_new", got, 32'h5555_AAAA);

        // W three cycles ahead of AW, response stalled; then AW ahead of W
        axi_write(2'd3, 32'hCAFE_0001, 4'hF, 3, 5);
        axi_write(2'd3, 32'h1234_0000, 4'hC, -2, 1);
        axi_read(2'd3, 2, got);
        chk("order_readback", got, 32'h1234_0001);

        // PWM 3/10 with direction set
        axi_write(2'd1, 32'd10, 4'hF, 0, 0);
        axi_write(2'd2, 32'd3, 4'hF, 0, 0);
        axi_write(2'd0, 32'h3, 4'hF, 0, 0);
        repeat (10) @(negedge ACLK);
        count_high(10, hi);
        chk("pwm_3_of_10", 32'(hi), 32'd3);
        count_high(10, hi);
        chk("pwm_3_of_10_again", 32'(hi), 32'd3);
        chk("pwm_dir_set", {31'b0, pwm_dir}, 32'd1);
        repeat (4) @(negedge ACLK);
        axi_write(2'd2, 32'd7, 4'hF, 0, 0);
        repeat (12) @(negedge ACLK);
        count_high(10, hi);
        chk("pwm_7_of_10", 32'(hi), 32'd7);
        axi_write(2'd2, 32'd12, 4'hF, 0, 0);
        repeat (12) @(negedge ACLK);
        count_high(10, hi);
        chk("pwm_duty_over_period", 32'(hi), 32'd10);
        axi_write(2'd1, 32'd0, 4'hF, 0, 0);
        repeat (12) @(negedge ACLK);
        count_high(10, hi);
        chk("pwm_period_zero", 32'(hi), 32'd0);

        // Reset while a response is pending and the PWM is running
        axi_write(2'd1, 32'd10, 4'hF, 0, 0);
        axi_write(2'd2, 32'd5, 4'hF, 0, 0);
        repeat (7) @(negedge ACLK);
        pend_v = 1'b1; pend_cyc = cyc + 1;
        pend_idx = 2'd3; pend_data = 32'h8765_4321; pend_strb = 4'hF;
        S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h8765_4321; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        @(negedge ACLK);
        chk("pre_reset_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
        chk("pre_reset_dir", {31'b0, pwm_dir}, 32'd1);
        #2 ARESETN = 1'b0;
        #1 check_all_outputs_zero("async_reset");
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        S_AXI_BREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("no_b_after_reset", {31'b0, S_AXI_BVALID}, 32'd0);
        end
        S_AXI_BREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            axi_read(2'(i), 0, got);
            chk("reset_readback", got, 32'd0);
        end

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            logic [1:0]  idx;
            logic [31:0] data;
            int          op, gap, bd, rd, dly;
            idx  = 2'($urandom_range(0, 3));
            data = $urandom;
            if (idx == 2'd0 && $urandom_range(0, 3) != 0) data[0] = 1'b1;
            if (idx == 2'd1) data[15:0] = 16'($urandom_range(0, 12));
            if (idx == 2'd2) data[15:0] = 16'($urandom_range(0, 14));
            op  = int'($urandom_range(0, 2));
            gap = int'($urandom_range(0, 6)) - 3;
            bd  = int'($urandom_range(0, 3));
            rd  = int'($urandom_range(0, 2));
            dly = int'($urandom_range(0, 4));
            case (op)
                0: axi_write(idx, data, 4'($urandom_range(1, 15)), gap, bd);
                1: axi_read(2'($urandom_range(0, 3)), rd, got);
                default: fork
                    axi_write(idx, data, 4'($urandom_range(1, 15)), gap, bd);
                    begin
                        repeat (dly) @(negedge ACLK);
                        axi_read(2'($urandom_range(0, 3)), rd, got);
                    end
                join
            endcase
            repeat (int'($urandom_range(0, 3))) @(negedge ACLK);
        end
        repeat (5) @(negedge ACLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
